// File: rtl/cache_set_assoc_l2_pkg.sv
// Shared FSM encoding and geometry helpers for the set-associative tag-only L2 model.
package cache_set_assoc_l2_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_WAIT = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    // Way-index width; a direct-mapped cache still carries a 1-bit way field.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_set_assoc_l2_lru_set.sv
// True-LRU age vector for one set: victim is lowest invalid way, else the oldest way.
// Ages update one cycle after an access strobe; no handshake, purely combinational victim output.
module cache_lru_set #(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             update,
    input  logic [WAY_W-1:0] access_way,
    input  logic [WAYS-1:0]  valid_mask,
    output logic [WAY_W-1:0] victim_way
);

    generate
        if (WAYS == 1) begin : g_dm
            logic unused_in;
            assign unused_in  = ^{clk, rst_n, update, access_way, valid_mask};
            assign victim_way = '0;
        end else begin : g_lru
            logic [WAY_W-1:0] age [WAYS];
            logic [WAY_W-1:0] inv_way;
            logic [WAY_W-1:0] old_way;
            logic             any_inv;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int w = 0; w < WAYS; w++) age[w] <= WAY_W'(w);
                end else if (update) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == access_way)
                            age[w] <= '0;
                        else if (age[w] < age[access_way])
                            age[w] <= age[w] + 1'b1;
                    end
                end
            end

            // Ages form a permutation of 0..WAYS-1, so exactly one way holds the max.
            always_comb begin
                inv_way = '0;
                old_way = '0;
                any_inv = 1'b0;
                for (int w = WAYS - 1; w >= 0; w--) begin
                    if (!valid_mask[w]) begin
                        inv_way = WAY_W'(w);
                        any_inv = 1'b1;
                    end
                    if (age[w] == WAY_W'(WAYS - 1)) old_way = WAY_W'(w);
                end
            end

            assign victim_way = any_inv ? inv_way : old_way;
        end
    endgenerate

endmodule

// File: rtl/cache_set_assoc_l2.sv
// N-way set-associative tag-only L2 model: hit responds 1 cycle after accept, miss MISS_LAT+1.
// One request in flight; req_ready low outside IDLE and while flush is asserted.
module cache_set_assoc_l2
    import cache_set_assoc_l2_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 4,
    parameter int WAYS     = 2,
    parameter int MISS_LAT = 4,
    parameter int CNT_W    = 16,
    localparam int WAY_W   = way_bits(WAYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [WAY_W-1:0]  resp_way,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int NUM_SETS = 1 << INDEX_W;
    localparam int BLK_W    = ADDR_W - OFFSET_W;
    localparam int TAG_W    = BLK_W - INDEX_W;
    localparam int LAT_W    = $clog2(MISS_LAT + 1);

    state_t state, state_next;

    logic [BLK_W-1:0]  blk_q;
    logic [LAT_W-1:0]  wait_cnt;
    logic [WAY_W-1:0]  victim_q;
    logic [TAG_W-1:0]  tag_mem   [NUM_SETS][WAYS];
    logic [WAYS-1:0]   valid_mem [NUM_SETS];
    logic [WAY_W-1:0]  set_victim [NUM_SETS];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [WAYS-1:0]    hit_vec;
    logic [WAY_W-1:0]   hit_way;
    logic               lookup_hit;

    logic accept, do_flush, hit_done, miss_done, lru_upd;
    logic [WAY_W-1:0] lru_way;

    logic unused_offset;
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    assign idx = blk_q[INDEX_W-1:0];
    assign tag = blk_q[BLK_W-1:INDEX_W];

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[idx][w] && tag_mem[idx][w] == tag) begin
                hit_vec[w] = 1'b1;
                hit_way    = WAY_W'(w);
            end
        end
    end

    assign lookup_hit = |hit_vec;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        do_flush   = 1'b0;
        hit_done   = 1'b0;
        miss_done  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !flush;
                if (flush) begin
                    do_flush   = 1'b1;
                    state_next = FLUSH;
                end else if (req_valid) begin
                    accept     = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookup_hit) begin
                    hit_done   = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (wait_cnt == '0) begin
                    miss_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign lru_upd = hit_done || miss_done;
    assign lru_way = hit_done ? hit_way : victim_q;

    // Transaction context and tags need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (accept) blk_q <= req_addr[ADDR_W-1:OFFSET_W];
        if (state == LOOKUP && !lookup_hit) begin
            wait_cnt <= LAT_W'(MISS_LAT - 1);
            victim_q <= set_victim[idx];
        end else if (state == MISS_WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
        if (miss_done) tag_mem[idx][victim_q] <= tag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) valid_mem[s] <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_way   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            resp_valid <= hit_done || miss_done;
            if (do_flush) begin
                for (int s = 0; s < NUM_SETS; s++) valid_mem[s] <= '0;
            end
            if (hit_done) begin
                resp_hit <= 1'b1;
                resp_way <= hit_way;
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end
            if (miss_done) begin
                resp_hit <= 1'b0;
                resp_way <= victim_q;
                valid_mem[idx][victim_q] <= 1'b1;
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
        end
    end

    generate
        for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
            cache_lru_set #(
                .WAYS  (WAYS),
                .WAY_W (WAY_W)
            ) u_lru (
                .clk        (clk),
                .rst_n      (rst_n),
                .update     (lru_upd && idx == INDEX_W'(s)),
                .access_way (lru_way),
                .valid_mask (valid_mem[s]),
                .victim_way (set_victim[s])
            );
        end
    endgenerate

endmodule

// File: tb/tb_cache_set_assoc_l2.sv
// Directed and randomized bench for cache_set_assoc_l2 against a recency-list cache model.
module tb_cache_set_assoc_l2;

    localparam int ADDR_W   = 11;
    localparam int OFFSET_W = 2;
    localparam int INDEX_W  = 4;
    localparam int WAYS     = 2;
    localparam int MISS_LAT = 4;
    localparam int CNT_W    = 16;
    localparam int NSETS    = 1 << INDEX_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              flush;
    logic              resp_valid;
    logic              resp_hit;
    logic [0:0]        resp_way;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    always #5 clk = ~clk;

    cache_set_assoc_l2 #(
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W),
        .INDEX_W  (INDEX_W),
        .WAYS     (WAYS),
        .MISS_LAT (MISS_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_way   (resp_way),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int checks = 0;
    int failures = 0;

    // Model: per set, line contents plus a recency list (most recent first).
    bit m_valid [NSETS][WAYS];
    int m_tag   [NSETS][WAYS];
    int m_order [NSETS][WAYS];
    int m_hits;
    int m_misses;

    function automatic void model_reset();
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_order[s][w] = w;
            end
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    endfunction

    function automatic void model_access(input int a, output bit hit, output int way);
        int s = (a >> OFFSET_W) % NSETS;
        int t = a >> (OFFSET_W + INDEX_W);
        int pos = 0;
        hit = 1'b0;
        way = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                hit = 1'b1;
                way = w;
            end
        if (hit) begin
            if (m_hits < (1 << CNT_W) - 1) m_hits++;
        end else begin
            for (int w = WAYS - 1; w >= 0; w--)
                if (!m_valid[s][w]) way = w;
            if (way < 0) way = m_order[s][WAYS-1];
            m_valid[s][way] = 1'b1;
            m_tag[s][way]   = t;
            if (m_misses < (1 << CNT_W) - 1) m_misses++;
        end
        for (int i = 0; i < WAYS; i++) if (m_order[s][i] == way) pos = i;
        for (int i = pos; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = way;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_req(input int a, input string tag);
        bit eh;
        int ew;
        int lat = 0;
        int n = 0;
        while (!req_ready && n < 10) begin
            tick();
            n++;
        end
        check({tag, ".ready_in"}, req_ready, 1);
        model_access(a, eh, ew);
        req_valid = 1'b1;
        req_addr  = a[ADDR_W-1:0];
        tick();
        req_valid = 1'b0;
        req_addr  = ADDR_W'($urandom);
        while (!resp_valid && lat < 30) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, eh ? 1 : MISS_LAT + 1);
        check({tag, ".hit"}, resp_hit, eh);
        check({tag, ".way"}, resp_way, ew);
        check({tag, ".hit_count"}, hit_count, m_hits);
        check({tag, ".miss_count"}, miss_count, m_misses);
        check({tag, ".ready_with_resp"}, req_ready, 1);
        tick();
        check({tag, ".resp_pulse"}, resp_valid, 0);
    endtask

    task automatic do_flush(input string tag);
        flush = 1'b1;
        #1;
        check({tag, ".ready_during_flush"}, req_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        check({tag, ".ready_flush_state"}, req_ready, 0);
        tick();
        check({tag, ".ready_after_flush"}, req_ready, 1);
        model_flush();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit eq [$];
        int wq [$];
        int accepts;
        int resps;
        int seen;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        do_reset();
        check("reset.ready", req_ready, 1);
        check("reset.resp_valid", resp_valid, 0);
        check("reset.hit_count", hit_count, 0);
        check("reset.miss_count", miss_count, 0);

        do_req(34, "t1.first");
        do_req(34, "t1.again");
        check("t1.hits", hit_count, 1);
        check("t1.misses", miss_count, 1);

        do_reset();
        do_req(512, "t2.a");
        do_req(576, "t2.b");
        do_req(512, "t2.c");
        do_req(640, "t2.d");
        do_req(576, "t2.e");
        check("t2.hits", hit_count, 1);
        check("t2.misses", miss_count, 4);

        do_req(34, "t3.a");
        do_req(200, "t3.b");
        do_req(34, "t3.c");

        do_flush("t4");
        do_req(34, "t4.after_flush");

        do_reset();
        req_valid = 1'b1;
        req_addr  = 11'd768;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        repeat (8) begin
            if (resp_valid) seen++;
            tick();
        end
        check("t5.no_resp", seen, 0);
        check("t5.hits", hit_count, 0);
        check("t5.misses", miss_count, 0);
        do_req(768, "t5.retry");

        accepts = 0;
        resps   = 0;
        req_addr  = 11'd34;
        req_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (resp_valid) begin
                resps++;
                if (eq.size() > 0) begin
                    check("t6.hit", resp_hit, eq.pop_front());
                    check("t6.way", resp_way, wq.pop_front());
                end
            end
            if (i == 23) begin
                req_valid = 1'b0;
            end else if (req_ready) begin
                bit h;
                int w;
                model_access(34, h, w);
                eq.push_back(h);
                wq.push_back(w);
                accepts++;
            end
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            if (resp_valid) begin
                resps++;
                if (eq.size() > 0) begin
                    check("t6.hit", resp_hit, eq.pop_front());
                    check("t6.way", resp_way, wq.pop_front());
                end
            end
            tick();
        end
        check("t6.resp_eq_accept", resps, accepts);
        check("t6.enough_accepts", accepts >= 5, 1);
        check("t6.hits", hit_count, m_hits);
        check("t6.misses", miss_count, m_misses);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_flush("rnd.flush");
            end else begin
                int a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2)
                        | $urandom_range(0, 3);
                do_req(a, "rnd.req");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
